hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage miniRV core; sequences the IF/ID and ID/EX registers and the PC.
- Keeps its own 3-deep scoreboard shadowing the EX, MEM and WB stages.
- From the scoreboard it generates forwarding selects, load-use stalls, bubble insertion (drives id_ex null_i) and redirect flushes.
- Holds a redirect that arrives during a data-memory freeze until the freeze ends.

Parameters:
- RA_W, 5, register-address width.
- PERF_W, 32, performance-counter width (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- id_valid_i  in  1  ID holds a real (non-null) instruction.
- id_rs1_i  in  RA_W  ID source register 1.
- id_rs2_i  in  RA_W  ID source register 2.
- id_rs1_used_i  in  1  instruction reads rs1.
- id_rs2_used_i  in  1  instruction reads rs2.
- id_wR_i  in  RA_W  ID destination register.
- id_rf_we_i  in  1  ID writes the register file.
- id_is_load_i  in  1  ID writeback source is DRAM.
- ex_redirect_i  in  1  taken branch/jump resolved in EX this cycle.
- mem_busy_i  in  1  data memory not ready; whole pipeline freezes.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF/ID.
- if_id_flush_o  out  1  load null into IF/ID.
- id_ex_null_o  out  1  insert bubble into ID/EX.
- pipe_freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_rs1_sel_o  out  2  0 = RF, 1 = EX, 2 = MEM, 3 = WB.
- fwd_rs2_sel_o  out  2  same encoding.
- state_o  out  2  FSM state.
- perf_stall_cnt_o  out  PERF_W  load-use stall cycles.
- perf_flush_cnt_o  out  PERF_W  redirect flushes.

Behaviour:
- Scoreboard entry per stage: {v, wR, we, ld}. Reset clears every v.
- Each non-frozen cycle:
  - WB <= MEM; MEM <= EX.
  - EX <= {id_valid_i & ~bubble, id_wR_i, id_rf_we_i, id_is_load_i}.
  - bubble = load-use stall or flush.
  - While frozen the scoreboard holds.
- Match(stage, rs) = v & we & wR != 0 & wR == rs & rs_used.
- Forwarding, combinational, youngest stage first: EX (non-load only) = 1, then MEM = 2, then WB = 3, else 0. A load in EX never forwards.
- load_use = id_valid_i & (Match(EX, rs1) | Match(EX, rs2)) & EX.ld.
- FSM states:
  - RUN = 0.
  - LU = 1: the cycle in which a load-use stall is issued.
  - FREEZE = 2.
  - FLUSH = 3: the cycle in which a flush is issued.
- Priority each cycle: freeze > redirect > load-use.
  - mem_busy_i = 1: pipe_freeze_o = pc_stall_o = if_id_stall_o = 1; flush and null outputs 0; state FREEZE.
    - An ex_redirect_i seen while frozen sets pend_redir.
    - In the first cycle with mem_busy_i = 0, the pending redirect is issued as a flush and pend_redir clears.
  - Redirect (ex_redirect_i or pend_redir): if_id_flush_o = 1, id_ex_null_o = 1, no stall; state FLUSH.
    - Overrides a simultaneous load-use stall, because the ID instruction is wrong-path.
  - load_use: pc_stall_o = if_id_stall_o = 1, id_ex_null_o = 1; state LU. Exactly one stall cycle per load; the next cycle forwards from MEM.
  - Otherwise RUN; all control outputs 0.
- Control outputs are combinational from inputs plus registered state. Scoreboard, pend_redir and state_o are registered.
- Reset (rst_i = 1 at a clock edge):
  - Clears the scoreboard, pend_redir and the counters.
  - state_o = 0.
  - Outputs after reset with id_valid_i = 0 and mem_busy_i = 0: every control output 0, fwd selects 0.
  - Reset mid-stall or mid-freeze abandons the operation. No pending redirect survives reset.

Optional Feature:
- HAZARD_PERF_EN defined:
  - perf_stall_cnt_o increments on every LU cycle.
  - perf_flush_cnt_o increments on every FLUSH cycle.
  - Both wrap modulo 2^PERF_W, are cleared by reset, and do not count while frozen.
- Not defined: counters are not built; both ports drive constant 0.

Decomposition:
- Package hazard_pkg holds:
  - FSM state encodings ST_RUN, ST_LU, ST_FREEZE, ST_FLUSH.
  - Forward encodings FWD_RF, FWD_EX, FWD_MEM, FWD_WB.
  - A scoreboard-entry typedef.
- One sub-module, fwd_sel: pure combinational per-operand priority select, instantiated twice.

Test Plan:
- Reset, then addi x5 in EX and ID reads x5 via rs1 -> fwd_rs1_sel_o = 1; no stall.
  - Next cycle with a new reader of x5 -> sel = 2; following cycle -> sel = 3.
- lw x6 in EX, ID add reads x6 via rs2 -> pc_stall_o = if_id_stall_o = id_ex_null_o = 1 for exactly 1 cycle, state_o = 1.
  - Next cycle fwd_rs2_sel_o = 2.
- Load into x0, ID reads x0 -> no stall, fwd sel 0.
- Redirect and load-use in the same cycle -> if_id_flush_o = 1, id_ex_null_o = 1, pc_stall_o = 0, state_o = 3.
- mem_busy_i high 3 cycles with ex_redirect_i pulsed in cycle 1:
  - 3 cycles of pipe_freeze_o = 1.
  - Flush issued in cycle 4.
  - Scoreboard unchanged across the freeze.
- With HAZARD_PERF_EN: 2 load-use stalls and 1 redirect -> counters read 2 and 1.
  - Assert rst_i mid-freeze -> both counters 0, no flush issued afterwards.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the miniRV hazard controller: FSM states, forward selects,
// scoreboard entry and the register-match helper.
package hazard_pkg;

    localparam int RA_W_PKG = 5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LU     = 2'd1,
        ST_FREEZE = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_t;

    typedef struct packed {
        logic                v;
        logic [RA_W_PKG-1:0] wr;
        logic                we;
        logic                ld;
    } sb_entry_t;

    // A load can only supply its value from MEM onwards, so callers clear allow_ld for EX.
    function automatic logic sb_hit(input sb_entry_t e, input logic [RA_W_PKG-1:0] rs,
                                    input logic used, input logic allow_ld);
        return e.v & e.we & (e.wr != '0) & (e.wr == rs) & used & (allow_ld | ~e.ld);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: ID decode info in, stall/flush/forward controls out.
interface hazard_ctrl_if #(
    parameter int RA_W   = 5,
    parameter int PERF_W = 32
);
    logic              id_valid_i;
    logic [RA_W-1:0]   id_rs1_i;
    logic [RA_W-1:0]   id_rs2_i;
    logic              id_rs1_used_i;
    logic              id_rs2_used_i;
    logic [RA_W-1:0]   id_wR_i;
    logic              id_rf_we_i;
    logic              id_is_load_i;
    logic              ex_redirect_i;
    logic              mem_busy_i;
    logic              pc_stall_o;
    logic              if_id_stall_o;
    logic              if_id_flush_o;
    logic              id_ex_null_o;
    logic              pipe_freeze_o;
    logic [1:0]        fwd_rs1_sel_o;
    logic [1:0]        fwd_rs2_sel_o;
    logic [1:0]        state_o;
    logic [PERF_W-1:0] perf_stall_cnt_o;
    logic [PERF_W-1:0] perf_flush_cnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               id_wR_i, id_rf_we_i, id_is_load_i, ex_redirect_i, mem_busy_i,
        input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_null_o, pipe_freeze_o,
               fwd_rs1_sel_o, fwd_rs2_sel_o, state_o, perf_stall_cnt_o, perf_flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               id_wR_i, id_rf_we_i, id_is_load_i, ex_redirect_i, mem_busy_i,
        output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_null_o, pipe_freeze_o,
               fwd_rs1_sel_o, fwd_rs2_sel_o, state_o, perf_stall_cnt_o, perf_flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select: youngest matching scoreboard stage wins.
module fwd_sel
    import hazard_pkg::*;
(
    input  sb_entry_t           i_ex,
    input  sb_entry_t           i_mem,
    input  sb_entry_t           i_wb,
    input  logic [RA_W_PKG-1:0] i_rs,
    input  logic                i_used,
    output fwd_t                o_sel
);
    always_comb begin
        o_sel = FWD_RF;
        if (sb_hit(i_ex, i_rs, i_used, 1'b0))
            o_sel = FWD_EX;
        else if (sb_hit(i_mem, i_rs, i_used, 1'b1))
            o_sel = FWD_MEM;
        else if (sb_hit(i_wb, i_rs, i_used, 1'b1))
            o_sel = FWD_WB;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage miniRV core: scoreboard, forwarding, load-use stall,
// freeze and redirect flush. Define HAZARD_PERF_EN to build the stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W   = RA_W_PKG,
    parameter int PERF_W = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    hazard_ctrl_if.slave bus
);
    sb_entry_t       r_sb_ex, r_sb_mem, r_sb_wb;
    logic            r_pend_redir;
    state_t          r_state;

    state_t          w_next_state;
    fwd_t            w_fwd_rs1, w_fwd_rs2;
    logic [RA_W-1:0] w_rs1, w_rs2;
    logic            w_ld_use, w_redir, w_bubble;

    assign w_rs1 = bus.id_rs1_i;
    assign w_rs2 = bus.id_rs2_i;

    fwd_sel u_fwd_rs1 (.i_ex(r_sb_ex), .i_mem(r_sb_mem), .i_wb(r_sb_wb),
                       .i_rs(w_rs1), .i_used(bus.id_rs1_used_i), .o_sel(w_fwd_rs1));
    fwd_sel u_fwd_rs2 (.i_ex(r_sb_ex), .i_mem(r_sb_mem), .i_wb(r_sb_wb),
                       .i_rs(w_rs2), .i_used(bus.id_rs2_used_i), .o_sel(w_fwd_rs2));

    assign w_ld_use = bus.id_valid_i & r_sb_ex.ld &
                      (sb_hit(r_sb_ex, w_rs1, bus.id_rs1_used_i, 1'b1) |
                       sb_hit(r_sb_ex, w_rs2, bus.id_rs2_used_i, 1'b1));
    assign w_redir  = bus.ex_redirect_i | r_pend_redir;
    // A redirect wins over load-use: the stalled ID instruction is wrong-path anyway.
    assign w_bubble = w_redir | w_ld_use;

    always_comb begin
        bus.pc_stall_o    = 1'b0;
        bus.if_id_stall_o = 1'b0;
        bus.if_id_flush_o = 1'b0;
        bus.id_ex_null_o  = 1'b0;
        bus.pipe_freeze_o = 1'b0;
        w_next_state      = ST_RUN;
        if (bus.mem_busy_i) begin
            bus.pipe_freeze_o = 1'b1;
            bus.pc_stall_o    = 1'b1;
            bus.if_id_stall_o = 1'b1;
            w_next_state      = ST_FREEZE;
        end else if (w_redir) begin
            bus.if_id_flush_o = 1'b1;
            bus.id_ex_null_o  = 1'b1;
            w_next_state      = ST_FLUSH;
        end else if (w_ld_use) begin
            bus.pc_stall_o    = 1'b1;
            bus.if_id_stall_o = 1'b1;
            bus.id_ex_null_o  = 1'b1;
            w_next_state      = ST_LU;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sb_ex.v    <= 1'b0;
            r_sb_mem.v   <= 1'b0;
            r_sb_wb.v    <= 1'b0;
            r_pend_redir <= 1'b0;
            r_state      <= ST_RUN;
        end else begin
            r_state <= w_next_state;
            if (bus.mem_busy_i) begin
                if (bus.ex_redirect_i)
                    r_pend_redir <= 1'b1;
            end else begin
                r_pend_redir <= 1'b0;
                r_sb_wb      <= r_sb_mem;
                r_sb_mem     <= r_sb_ex;
                r_sb_ex      <= '{v:  bus.id_valid_i & ~w_bubble,
                                  wr: bus.id_wR_i,
                                  we: bus.id_rf_we_i,
                                  ld: bus.id_is_load_i};
            end
        end
    end

    assign bus.fwd_rs1_sel_o = w_fwd_rs1;
    assign bus.fwd_rs2_sel_o = w_fwd_rs2;
    assign bus.state_o       = r_state;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;

    // Freeze has top priority, so LU/FLUSH decisions never occur while frozen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_next_state == ST_LU)
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if (w_next_state == ST_FLUSH)
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
        end
    end

    assign bus.perf_stall_cnt_o = r_stall_cnt;
    assign bus.perf_flush_cnt_o = r_flush_cnt;
`else
    assign bus.perf_stall_cnt_o = {PERF_W{1'b0}};
    assign bus.perf_flush_cnt_o = {PERF_W{1'b0}};
`endif

endmodule
